io_bus_ctrl: RTL

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

---
 rtl/io_bus_pkg.sv | 24 ++
 rtl/io_sync.sv | 32 +++
 rtl/io_bus_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the memory-mapped board I/O controller: region code,
// register offsets and FSM state encoding.
package io_bus_pkg;

  localparam logic [3:0] IO_REGION = 4'hF;

  localparam logic [7:0] OFF_HEX     = 8'h00;
  localparam logic [7:0] OFF_LEDR    = 8'h04;
  localparam logic [7:0] OFF_LEDG    = 8'h08;
  localparam logic [7:0] OFF_KEY     = 8'h10;
  localparam logic [7:0] OFF_SW      = 8'h14;
  localparam logic [7:0] OFF_KEYEDGE = 8'h18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_RESP    = 2'd2
  } io_state_e;

  function automatic logic is_io_region(input logic [3:0] region);
    return region == IO_REGION;
  endfunction

endpackage

// File: rtl/io_sync.sv
// Multi-flop synchronizer for asynchronous board inputs; all stages clear on reset.
module io_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/io_bus_ctrl.sv
// Board I/O bus controller: decodes 0xF-region loads/stores into a 3-cycle
// stalled access. Optional sticky key-edge register enabled by IO_KEY_EDGE_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no access in flight; operands latched when an I/O access appears
// ST_CAPTURE | read mux registered into rdata, stores committed at cycle end
// ST_RESP    | rdata presented with ioRdValid, pipeline released
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int DBITS       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             isLoad,
  input  logic             isStore,
  input  logic [9:0]       SW,
  input  logic [3:0]       KEY,
  output logic             stall,
  output logic [DBITS-1:0] rdata,
  output logic             ioRdValid,
  output logic             dataWrtEn,
  output logic [9:0]       ledr,
  output logic [7:0]       ledg,
  output logic [15:0]      hex
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
    $error("io_bus_ctrl: SYNC_STAGES must be 2 or 3");
  end

  io_state_e        state_q, state_d;
  logic [7:0]       off_q, off_d;
  logic [15:0]      wd_q, wd_d;
  logic             st_q, st_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic [9:0]       ledr_q, ledr_d;
  logic [7:0]       ledg_q, ledg_d;
  logic [15:0]      hex_q, hex_d;

  logic [9:0]       sw_sync;
  logic [3:0]       key_sync;
  logic [3:0]       keyedge_val;
  logic [3:0]       kedge_clr;
  logic             io_acc;
  logic [DBITS-1:0] rd_val;

  io_sync #(.WIDTH(10), .STAGES(SYNC_STAGES)) u_sync_sw (
    .clk   (clk),
    .reset (reset),
    .din   (SW),
    .dout  (sw_sync)
  );

  io_sync #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync_key (
    .clk   (clk),
    .reset (reset),
    .din   (KEY),
    .dout  (key_sync)
  );

  assign io_acc    = (isLoad | isStore) & is_io_region(addr[31:28]);
  assign dataWrtEn = isStore & ~io_acc;

  always_comb begin
    rd_val = '0;
    case (off_q)
      OFF_SW:      rd_val = {{(DBITS-10){1'b0}}, sw_sync};
      OFF_KEY:     rd_val = {{(DBITS-4){1'b0}}, key_sync};
      OFF_KEYEDGE: rd_val = {{(DBITS-4){1'b0}}, keyedge_val};
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    wd_d      = wd_q;
    st_d      = st_q;
    rdata_d   = rdata_q;
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
    hex_d     = hex_q;
    stall     = 1'b0;
    ioRdValid = 1'b0;
    kedge_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (io_acc) begin
          stall   = 1'b1;
          off_d   = addr[7:0];
          wd_d    = wdata[15:0];
          st_d    = isStore;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        stall   = 1'b1;
        rdata_d = st_q ? '0 : rd_val;
        if (st_q) begin
          case (off_q)
            OFF_HEX:     hex_d     = wd_q;
            OFF_LEDR:    ledr_d    = wd_q[9:0];
            OFF_LEDG:    ledg_d    = wd_q[7:0];
            OFF_KEYEDGE: kedge_clr = wd_q[3:0];
            default:     ;
          endcase
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        ioRdValid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      wd_q    <= '0;
      st_q    <= 1'b0;
      rdata_q <= '0;
      ledr_q  <= '0;
      ledg_q  <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      wd_q    <= wd_d;
      st_q    <= st_d;
      rdata_q <= rdata_d;
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      hex_q   <= hex_d;
    end
  end

`ifdef IO_KEY_EDGE_EN
  logic [3:0] key_prev_q, key_prev_d;
  logic [3:0] keyedge_q, keyedge_d;

  // A fall seen in the same cycle as a clear keeps its bit set.
  always_comb begin
    key_prev_d = key_sync;
    keyedge_d  = (keyedge_q & ~kedge_clr) | (key_prev_q & ~key_sync);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev_q <= '0;
      keyedge_q  <= '0;
    end else begin
      key_prev_q <= key_prev_d;
      keyedge_q  <= keyedge_d;
    end
  end

  assign keyedge_val = keyedge_q;
`else
  logic unused_kedge;
  assign unused_kedge = ^kedge_clr;
  assign keyedge_val  = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{addr, wdata};

  assign rdata = rdata_q;
  assign ledr  = ledr_q;
  assign ledg  = ledg_q;
  assign hex   = hex_q;

endmodule
